// File: rtl/iir_meter_pkg.sv
// Shared widths, default tuning constants and LED threshold helper for the
// audio level meter family.
package iir_meter_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LEVEL_W  = 15;

    localparam int AVG_SHIFT_DEF    = 6;
    localparam int HOLD_SAMPLES_DEF = 4800;
    localparam int DECAY_SHIFT_DEF  = 10;
    localparam int CLIP_LEVEL_DEF   = 32000;
    localparam int CLIP_HOLD_DEF    = 24000;
    localparam int WINDOW_DEF       = 1024;
    localparam int NUM_LEDS_DEF     = 8;

    // Segment i of an n-segment bar lights at full scale >> (n - i): 6 dB per step.
    function automatic logic [LEVEL_W-1:0] led_threshold(input int i, input int n);
        logic [LEVEL_W:0] full;
        full = {1'b1, {LEVEL_W{1'b0}}};
        full = full >> (n - i);
        return full[LEVEL_W-1:0];
    endfunction

endpackage

// File: rtl/iir_level_meter_abs_sat.sv
// Combinational saturating magnitude: 16-bit signed sample to 15-bit |x|,
// with the most negative code clamped to full scale.
module audio_abs_sat
    import iir_meter_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic        [LEVEL_W-1:0]  magnitude
);

    logic [SAMPLE_W-1:0] negated;

    assign negated = ~sample + {{(SAMPLE_W-1){1'b0}}, 1'b1};

    always_comb begin
        magnitude = sample[LEVEL_W-1:0];
        if (sample == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            magnitude = {LEVEL_W{1'b1}};
        end else if (sample[SAMPLE_W-1]) begin
            magnitude = negated[LEVEL_W-1:0];
        end
    end

endmodule

// File: rtl/iir_level_meter.sv
// Level meter for the IIR filter output: leaky average, peak hold with decay,
// thermometer LED bar, held clip flag and per-window maximum.
module iir_level_meter
    import iir_meter_pkg::*;
#(
    parameter int AVG_SHIFT    = AVG_SHIFT_DEF,
    parameter int HOLD_SAMPLES = HOLD_SAMPLES_DEF,
    parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
    parameter int CLIP_LEVEL   = CLIP_LEVEL_DEF,
    parameter int CLIP_HOLD    = CLIP_HOLD_DEF,
    parameter int WINDOW       = WINDOW_DEF,
    parameter int NUM_LEDS     = NUM_LEDS_DEF
) (
    input  logic                       lr_clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic signed [SAMPLE_W-1:0] audio_in,
    output logic        [LEVEL_W-1:0]  avg_level,
    output logic        [LEVEL_W-1:0]  peak_level,
    output logic        [NUM_LEDS-1:0] leds,
    output logic                       clip,
    output logic        [LEVEL_W-1:0]  win_peak,
    output logic                       win_valid
);

    localparam int ACC_W  = LEVEL_W + AVG_SHIFT;
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam int CLIP_W = $clog2(CLIP_HOLD + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
    localparam logic [CLIP_W-1:0]  CLIP_LOAD = CLIP_W'(CLIP_HOLD);
    localparam logic [LEVEL_W-1:0] CLIP_THR  = LEVEL_W'(CLIP_LEVEL);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);

    logic [LEVEL_W-1:0]  mag;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [LEVEL_W-1:0]  peak_reg;
    logic [LEVEL_W-1:0]  peak_next;
    logic [LEVEL_W-1:0]  decay_step;
    logic [HOLD_W-1:0]   hold_reg;
    logic [HOLD_W-1:0]   hold_next;
    logic [CLIP_W-1:0]   clip_cnt_reg;
    logic [CLIP_W-1:0]   clip_cnt_next;
    logic [WIN_W-1:0]    win_cnt_reg;
    logic [LEVEL_W-1:0]  run_max_reg;
    logic [LEVEL_W-1:0]  run_max_next;
    logic [NUM_LEDS-1:0] leds_next;

    audio_abs_sat u_abs (
        .sample    (audio_in),
        .magnitude (mag)
    );

    // acc + a can exceed ACC_W bits transiently, but the final value always
    // fits, so modular arithmetic at ACC_W bits gives the exact result.
    assign acc_next   = acc_reg + ACC_W'(mag) - (acc_reg >> AVG_SHIFT);
    assign avg_level  = acc_reg[ACC_W-1:AVG_SHIFT];
    assign peak_level = peak_reg;

    assign decay_step   = (peak_reg >> DECAY_SHIFT) | LEVEL_W'(1);
    assign run_max_next = (mag > run_max_reg) ? mag : run_max_reg;

    always_comb begin
        peak_next = peak_reg;
        hold_next = hold_reg;
        if (clear) begin
            peak_next = '0;
            hold_next = '0;
        end else if (mag > peak_reg) begin
            peak_next = mag;
            hold_next = HOLD_LOAD;
        end else if (hold_reg != '0) begin
            hold_next = hold_reg - HOLD_W'(1);
        end else if (peak_reg != '0) begin
            peak_next = (decay_step >= peak_reg) ? '0 : peak_reg - decay_step;
        end
    end

    always_comb begin
        clip_cnt_next = clip_cnt_reg;
        if (clear) begin
            clip_cnt_next = '0;
        end else if (mag >= CLIP_THR) begin
            clip_cnt_next = CLIP_LOAD;
        end else if (clip_cnt_reg != '0) begin
            clip_cnt_next = clip_cnt_reg - CLIP_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            assign leds_next[gi] = (peak_next >= led_threshold(gi, NUM_LEDS));
        end
    endgenerate

    always_ff @(posedge lr_clk) begin
        if (reset) begin
            acc_reg      <= '0;
            peak_reg     <= '0;
            hold_reg     <= '0;
            leds         <= '0;
            clip_cnt_reg <= '0;
            clip         <= 1'b0;
            win_cnt_reg  <= '0;
            run_max_reg  <= '0;
            win_peak     <= '0;
            win_valid    <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            peak_reg     <= peak_next;
            hold_reg     <= hold_next;
            leds         <= leds_next;
            clip_cnt_reg <= clip_cnt_next;
            clip         <= (clip_cnt_next != '0);
            if (clear) begin
                win_cnt_reg <= '0;
                run_max_reg <= '0;
                win_valid   <= 1'b0;
            end else if (win_cnt_reg == WIN_LAST) begin
                win_peak    <= run_max_next;
                win_valid   <= 1'b1;
                run_max_reg <= '0;
                win_cnt_reg <= '0;
            end else begin
                run_max_reg <= run_max_next;
                win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                win_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iir_level_meter.sv
// Directed bench for iir_level_meter: a sample-history model is checked against
// every output after each sample, plus hand-computed expectations per scenario.
module tb_iir_level_meter;

    localparam int HOLD_SAMPLES = 4800;
    localparam int CLIP_LEVEL   = 32000;
    localparam int CLIP_HOLD    = 24000;
    localparam int WINDOW       = 1024;
    localparam int NUM_LEDS     = 8;
    localparam int AVG_DIV      = 64;
    localparam int DECAY_DIV    = 1024;

    logic               lr_clk = 1'b0;
    logic               reset = 1'b1;
    logic               clear = 1'b0;
    logic signed [15:0] audio_in = '0;
    logic        [14:0] avg_level;
    logic        [14:0] peak_level;
    logic        [7:0]  leds;
    logic               clip;
    logic        [14:0] win_peak;
    logic               win_valid;

    int checks = 0;
    int errors = 0;

    // Model state: history-based view of the meter.
    int m_acc = 0;
    int m_peak = 0;
    int m_hold_left = 0;
    int m_since_clip = -1;
    int m_win_peak = 0;
    bit m_win_valid = 1'b0;
    int win_q[$];

    iir_level_meter dut (
        .lr_clk     (lr_clk),
        .reset      (reset),
        .clear      (clear),
        .audio_in   (audio_in),
        .avg_level  (avg_level),
        .peak_level (peak_level),
        .leds       (leds),
        .clip       (clip),
        .win_peak   (win_peak),
        .win_valid  (win_valid)
    );

    always #5 lr_clk = ~lr_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_leds(input int peak);
        int lit;
        lit = 0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (peak >= (32768 >> (NUM_LEDS - i))) lit++;
        end
        return (1 << lit) - 1;
    endfunction

    // Apply one sample, advance the model, compare every output.
    task automatic step(input int s, input bit clr, input bit rst);
        int a;
        int mx;
        audio_in = 16'(s);
        clear    = clr;
        reset    = rst;
        @(posedge lr_clk);
        #1;
        a = (s < 0) ? -s : s;
        if (a > 32767) a = 32767;
        if (rst) begin
            m_acc = 0; m_peak = 0; m_hold_left = 0; m_since_clip = -1;
            m_win_peak = 0; m_win_valid = 1'b0; win_q.delete();
        end else begin
            m_acc = m_acc + a - m_acc / AVG_DIV;
            m_win_valid = 1'b0;
            if (clr) begin
                m_peak = 0; m_hold_left = 0; m_since_clip = -1; win_q.delete();
            end else begin
                if (a > m_peak) begin
                    m_peak = a;
                    m_hold_left = HOLD_SAMPLES;
                end else if (m_hold_left > 0) begin
                    m_hold_left--;
                end else if (m_peak > 0) begin
                    m_peak = m_peak - ((m_peak / DECAY_DIV) | 1);
                    if (m_peak < 0) m_peak = 0;
                end
                if (a >= CLIP_LEVEL) m_since_clip = 0;
                else if (m_since_clip >= 0) m_since_clip++;
                win_q.push_back(a);
                if (win_q.size() == WINDOW) begin
                    mx = 0;
                    foreach (win_q[k]) if (win_q[k] > mx) mx = win_q[k];
                    m_win_peak = mx;
                    m_win_valid = 1'b1;
                    win_q.delete();
                end
            end
        end
        chk("avg_level", int'(avg_level), m_acc / AVG_DIV);
        chk("peak_level", int'(peak_level), m_peak);
        chk("leds", int'(leds), exp_leds(m_peak));
        chk("clip", int'(clip), (m_since_clip >= 0 && m_since_clip < CLIP_HOLD) ? 1 : 0);
        chk("win_valid", int'(win_valid), int'(m_win_valid));
        chk("win_peak", int'(win_peak), m_win_peak);
        if (win_valid) $display("window: win_peak=%0d at t=%0t", win_peak, $time);
    endtask

    initial begin
        int n;
        int prev;
        bit flag;
        bit done;
        int pulses;

        // 1. Reset with nonzero input, then idle.
        for (int i = 0; i < 3; i++) step(12345, 1'b0, 1'b1);
        chk("rst_avg", int'(avg_level), 0);
        chk("rst_peak", int'(peak_level), 0);
        chk("rst_leds", int'(leds), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_win", int'(win_peak) + int'(win_valid), 0);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0);
        chk("idle_peak", int'(peak_level), 0);
        $display("reset: done, avg=%0d peak=%0d", avg_level, peak_level);

        // 2. Constant -1000.
        step(-1000, 1'b0, 1'b0);
        chk("const_peak", int'(peak_level), 1000);
        chk("const_leds", int'(leds), 8'h07);
        for (int i = 1; i < 900; i++) step(-1000, 1'b0, 1'b0);
        chk("const_avg_settled", (avg_level >= 999 && avg_level <= 1001) ? 1 : 0, 1);
        for (int i = 900; i < 1000; i++) step(-1000, 1'b0, 1'b0);
        chk("const_clip", int'(clip), 0);
        $display("constant: avg=%0d peak=%0d leds=%b", avg_level, peak_level, leds);

        // 3. Hold and decay.
        step(20000, 1'b0, 1'b0);
        chk("hold_start", int'(peak_level), 20000);
        n = 0;
        for (int i = 0; i < HOLD_SAMPLES; i++) begin
            step(0, 1'b0, 1'b0);
            if (peak_level == 15'd20000) n++;
        end
        chk("hold_len", n, HOLD_SAMPLES);
        step(0, 1'b0, 1'b0);
        chk("decay_first", int'(peak_level), 19981);
        prev = 19981; flag = 1'b1; done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            step(0, 1'b0, 1'b0);
            if (int'(peak_level) > prev) flag = 1'b0;
            prev = int'(peak_level);
            if (peak_level == '0) done = 1'b1;
        end
        chk("decay_monotonic", int'(flag), 1);
        chk("decay_to_zero", int'(done), 1);
        $display("decay: reached peak=%0d", peak_level);

        // 4. Clip on most-negative code.
        step(-32768, 1'b0, 1'b0);
        chk("clip_set", int'(clip), 1);
        chk("clip_leds", int'(leds), 8'hFF);
        chk("clip_sat_peak", int'(peak_level), 32767);
        step(-32768, 1'b0, 1'b0);
        step(-32768, 1'b0, 1'b0);
        n = clip ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) begin
            step(0, 1'b0, 1'b0);
            if (clip) n++;
            else done = 1'b1;
        end
        chk("clip_hold_len", n, CLIP_HOLD);
        $display("clip: high for %0d samples", n);

        // 5. Window maxima, aligned by clear.
        step(0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < WINDOW; i++) begin
            step((i == 10) ? 5000 : 3000, 1'b0, 1'b0);
            if (win_valid) pulses++;
        end
        chk("win_mid_valid", int'(win_valid), 1);
        chk("win_mid_peak", int'(win_peak), 5000);
        for (int i = 0; i < WINDOW; i++) begin
            step(3000, 1'b0, 1'b0);
            if (win_valid) pulses++;
        end
        chk("win_flat_peak", int'(win_peak), 3000);
        for (int i = 0; i < WINDOW; i++) begin
            step((i == WINDOW - 1) ? 9000 : 3000, 1'b0, 1'b0);
            if (win_valid) pulses++;
        end
        chk("win_last_peak", int'(win_peak), 9000);
        chk("win_pulses", pulses, 3);

        // 6. Clear coincident with a loud sample, then mid-window reset.
        prev = int'(avg_level);
        step(30000, 1'b1, 1'b0);
        chk("clear_peak", int'(peak_level), 0);
        chk("clear_clip", int'(clip), 0);
        chk("clear_leds", int'(leds), 0);
        chk("clear_avg_moves", (int'(avg_level) > prev) ? 1 : 0, 1);
        chk("clear_win_hold", int'(win_peak), 9000);
        $display("clear: avg %0d -> %0d, peak=%0d", prev, avg_level, peak_level);
        for (int i = 0; i < 500; i++) step(3000, 1'b0, 1'b0);
        step(3000, 1'b0, 1'b1);
        chk("midrst_win_peak", int'(win_peak), 0);
        n = 0; done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step(3000, 1'b0, 1'b0);
            n++;
            if (win_valid) done = 1'b1;
        end
        chk("midrst_win_delay", n, WINDOW);
        chk("midrst_win_value", int'(win_peak), 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
